// File: rtl/march_if.sv
`timescale 1ns/1ps
// Bundle between the March C- controller and the RAM/comparator it drives.
interface march_if #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
);
   logic              start;
   logic              eq;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_t;
   logic              we;
   logic              re;
   logic              cmp_en;
   logic              busy;
   logic              done;
   logic              fail;
   logic [ADDR_W-1:0] fail_addr;
   logic [7:0]        fail_count;

   modport master (
      input  start, eq,
      output addr, data_t, we, re, cmp_en, busy, done, fail, fail_addr, fail_count
   );

   modport slave (
      output start, eq,
      input  addr, data_t, we, re, cmp_en, busy, done, fail, fail_addr, fail_count
   );
endinterface

// File: rtl/march_controller.sv
`timescale 1ns/1ps
// March C- memory test sequencer: walks six elements over the RAM, writes patterns,
// checks read-back via an external comparator and records mismatches.
module march_controller #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input logic      clk,
   input logic      rst_n,
   march_if.master  bus
);

   typedef enum logic [2:0] {StIdle, StWr, StRd, StCmp, StDone} state_e;

   localparam logic [2:0]        LastElem = 3'd5;
   localparam logic [ADDR_W-1:0] AddrMax  = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] Ones     = {DATA_W{1'b1}};
   localparam logic [7:0]        CntMax   = 8'hFF;

   state_e            state_q, state_d;
   logic [2:0]        elem_q, elem_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_t;
   logic              fail_q, fail_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [7:0]        fail_count_q, fail_count_d;

   // Element decode: M0 w0 | M1 r0,w1 | M2 r1,w0 | M3 v r0,w1 | M4 v r1,w0 | M5 r0
   logic       elem_down, rd_one, wr_one, elem_has_wr, next_down, last_addr, advance;
   logic [2:0] elem_next;

   always_comb begin
      elem_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
      rd_one      = (elem_q == 3'd2) || (elem_q == 3'd4);
      wr_one      = (elem_q == 3'd1) || (elem_q == 3'd3);
      elem_has_wr = (elem_q != LastElem);
      elem_next   = elem_q + 3'd1;
      next_down   = (elem_next == 3'd3) || (elem_next == 3'd4);
      last_addr   = elem_down ? (addr_q == '0) : (addr_q == AddrMax);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         elem_q       <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         fail_q       <= 1'b0;
         fail_addr_q  <= '0;
         fail_count_q <= '0;
      end else begin
         elem_q       <= elem_d;
         addr_q       <= addr_d;
         data_q       <= data_t;
         fail_q       <= fail_d;
         fail_addr_q  <= fail_addr_d;
         fail_count_q <= fail_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      elem_d       = elem_q;
      addr_d       = addr_q;
      fail_d       = fail_q;
      fail_addr_d  = fail_addr_q;
      fail_count_d = fail_count_q;
      advance      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               state_d      = StWr;
               elem_d       = '0;
               addr_d       = '0;
               fail_d       = 1'b0;
               fail_addr_d  = '0;
               fail_count_d = '0;
            end
         end
         StWr: advance = 1'b1;
         StRd: state_d = StCmp;
         StCmp: begin
            if (!bus.eq) begin
               fail_d = 1'b1;
               if (fail_count_q != CntMax) fail_count_d = fail_count_q + 8'd1;
               if (!fail_q) fail_addr_d = addr_q;
            end
            if (elem_has_wr) state_d = StWr;
            else             advance = 1'b1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Write is always the last op of an element, so finishing it moves the address on.
      if (advance) begin
         if (last_addr) begin
            if (elem_q == LastElem) begin
               state_d = StDone;
            end else begin
               elem_d  = elem_next;
               addr_d  = next_down ? AddrMax : '0;
               state_d = StRd;
            end
         end else begin
            addr_d  = elem_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
            state_d = (elem_q == '0) ? StWr : StRd;
         end
      end
   end

   always_comb begin
      data_t = data_q;
      if (state_q == StWr)  data_t = wr_one ? Ones : '0;
      if (state_q == StCmp) data_t = rd_one ? Ones : '0;
   end

   assign bus.addr       = addr_q;
   assign bus.data_t     = data_t;
   assign bus.we         = (state_q == StWr);
   assign bus.re         = (state_q == StRd);
   assign bus.cmp_en     = (state_q == StCmp);
   assign bus.busy       = (state_q == StWr) || (state_q == StRd) || (state_q == StCmp);
   assign bus.done       = (state_q == StDone);
   assign bus.fail       = fail_q;
   assign bus.fail_addr  = fail_addr_q;
   assign bus.fail_count = fail_count_q;

endmodule

// File: tb/tb_march_controller.sv
`timescale 1ns/1ps
// Directed bench for march_controller with a 16x8 RAM model and optional stuck-at fault.
module tb_march_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   march_if #(.ADDR_W(4), .DATA_W(8)) bus ();

   march_controller #(.ADDR_W(4), .DATA_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   logic [7:0] mem [16];
   logic [7:0] ramout;
   bit         fault_on;

   always_ff @(posedge clk) begin
      if (bus.we) mem[bus.addr] <= (fault_on && bus.addr == 4'd5) ? (bus.data_t & 8'hFE)
                                                                    : bus.data_t;
      if (bus.re) ramout <= mem[bus.addr];
   end
   assign bus.eq = (ramout == bus.data_t);

   int errors = 0;
   int checks = 0;
   int proto_err = 0;

   logic       we_log  [256];
   logic       re_log  [256];
   logic [3:0] addr_log[256];
   logic [7:0] data_log[256];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_addr"},  32'(bus.addr), 0);
      check({pfx, "_data"},  32'(bus.data_t), 0);
      check({pfx, "_we"},    32'(bus.we), 0);
      check({pfx, "_re"},    32'(bus.re), 0);
      check({pfx, "_cmp"},   32'(bus.cmp_en), 0);
      check({pfx, "_busy"},  32'(bus.busy), 0);
      check({pfx, "_done"},  32'(bus.done), 0);
      check({pfx, "_fail"},  32'(bus.fail), 0);
      check({pfx, "_faddr"}, 32'(bus.fail_addr), 0);
      check({pfx, "_fcnt"},  32'(bus.fail_count), 0);
   endtask

   // Called at a negedge with the DUT idle. Pulses start, then follows the run cycle by cycle.
   task automatic run_test(input int repulse_at, input int stop_at, output int nbusy,
                           output int ndone, output int done_cyc, output logic fail0,
                           output logic [7:0] cnt0);
      logic       prev_re;
      logic [3:0] prev_addr;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      nbusy = 0; ndone = 0; done_cyc = -1; prev_re = 1'b0; prev_addr = '0;
      fail0 = bus.fail; cnt0 = bus.fail_count;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc == stop_at) break;
         if (32'(bus.we) + 32'(bus.re) + 32'(bus.cmp_en) > 1) proto_err++;
         if (bus.cmp_en && !(prev_re && prev_addr == bus.addr)) proto_err++;
         if (bus.done && bus.busy) proto_err++;
         prev_re = bus.re; prev_addr = bus.addr;
         if (bus.busy) begin
            if (nbusy < 256) begin
               we_log[nbusy] = bus.we; re_log[nbusy] = bus.re;
               addr_log[nbusy] = bus.addr; data_log[nbusy] = bus.data_t;
            end
            nbusy++;
         end
         bus.start = (cyc == repulse_at);
         if (bus.done) begin
            ndone++;
            done_cyc = cyc;
            break;
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      if (ndone != 0) @(negedge clk);
   endtask

   int         nb, nd, dc, stray;
   logic       f0;
   logic [7:0] c0;

   initial begin
      rst_n = 1'b0; bus.start = 1'b0; fault_on = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("rst");
      rst_n = 1'b1;
      @(negedge clk);

      // Fault-free run with sequence checks
      run_test(-1, -1, nb, nd, dc, f0, c0);
      check("ff_busy", nb, 240);
      check("ff_done", nd, 1);
      check("ff_done_cyc", dc, 240);
      check("ff_fail", 32'(bus.fail), 0);
      check("ff_fcnt", 32'(bus.fail_count), 0);
      check("ff_idle_busy", 32'(bus.busy), 0);
      check("m0_we", 32'(we_log[0]), 1);
      check("m0_addr", 32'(addr_log[0]), 0);
      check("m0_data", 32'(data_log[0]), 32'h00);
      check("m1_rd", 32'(re_log[16]), 1);
      check("m1_we", 32'(we_log[18]), 1);
      check("m1_data", 32'(data_log[18]), 32'hFF);
      check("m2_cmp_exp", 32'(data_log[65]), 32'hFF);
      check("m3_re", 32'(re_log[112]), 1);
      check("m3_addr", 32'(addr_log[112]), 15);
      check("m5_last_addr", 32'(addr_log[239]), 15);

      // Stuck-at-0 on bit0 at addr 5
      fault_on = 1'b1;
      run_test(-1, -1, nb, nd, dc, f0, c0);
      check("flt_busy", nb, 240);
      check("flt_done", nd, 1);
      check("flt_fail", 32'(bus.fail), 1);
      check("flt_faddr", 32'(bus.fail_addr), 5);
      check("flt_fcnt", 32'(bus.fail_count), 2);
      repeat (3) @(negedge clk);
      check("hold_fail", 32'(bus.fail), 1);
      check("hold_faddr", 32'(bus.fail_addr), 5);
      check("hold_fcnt", 32'(bus.fail_count), 2);

      // Clean rerun with a start re-pulse at busy cycle 50
      fault_on = 1'b0;
      run_test(50, -1, nb, nd, dc, f0, c0);
      check("rr_fail_at_start", 32'(f0), 0);
      check("rr_fcnt_at_start", 32'(c0), 0);
      check("rr_busy", nb, 240);
      check("rr_done_cyc", dc, 240);
      check("rr_fail", 32'(bus.fail), 0);

      // Reset in the middle of a failing run
      fault_on = 1'b1;
      run_test(-1, 100, nb, nd, dc, f0, c0);
      check("mid_fail_pre", 32'(bus.fail), 1);
      rst_n = 1'b0;
      #1;
      check_zero("mid");
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done || bus.busy) stray++;
      end
      check("mid_no_done", stray, 0);
      fault_on = 1'b0;
      run_test(-1, -1, nb, nd, dc, f0, c0);
      check("post_busy", nb, 240);
      check("post_done", nd, 1);
      check("post_fail", 32'(bus.fail), 0);

      check("protocol", proto_err, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/march_controller.md
MARCH_CONTROLLER -- requirements
Module: march_controller

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width; the RAM depth N is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 8, RAM word and comparator operand width.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 eq  input  1  comparator equal flag (ramout == data_t), sampled only while cmp_en=1.
REQ-008 addr  output  ADDR_W  RAM address.
REQ-009 data_t  output  DATA_W  write data; expected value while cmp_en=1; drives the comparator.
REQ-010 we  output  1  RAM write enable.
REQ-011 re  output  1  RAM read enable; RAM read latency is 1 cycle.
REQ-012 cmp_en  output  1  comparator result valid this cycle.
REQ-013 busy  output  1  test running.
REQ-014 done  output  1  one-cycle pulse at end of test.
REQ-015 fail  output  1  sticky mismatch flag.
REQ-016 fail_addr  output  ADDR_W  address of the first mismatch.
REQ-017 fail_count  output  8  mismatch count, saturating at 255.

Function
REQ-018 SHALL execute March C- in this order:
- M0 up(w0)
- M1 up(r0,w1)
- M2 up(r1,w0)
- M3 down(r0,w1)
- M4 down(r1,w0)
- M5 up(r0)
REQ-019 Pattern values SHALL be: 0 = all-zeros; 1 = all-ones ({DATA_W{1'b1}}).
REQ-020 Up elements SHALL run addr 0..N-1; down elements SHALL run addr N-1..0.
REQ-021 All operations of an element SHALL complete at one address before addr advances.
REQ-022 FSM states SHALL be IDLE, WR, RD, CMP, DONE.
REQ-023 WR SHALL last 1 cycle: we=1, data_t=pattern.
REQ-024 A read SHALL take 2 cycles: RD (re=1), then CMP (cmp_en=1, data_t=expected, addr held).
REQ-025 addr SHALL be stable during RD and CMP.
REQ-026 In every cycle, at most one of we, re, cmp_en SHALL be 1.
REQ-027 Outside WR and CMP, data_t SHALL hold its last value.
REQ-028 IDLE->WR SHALL occur on start=1; busy SHALL rise in the same cycle WR is first entered.
REQ-029 After the last CMP of M5, the FSM SHALL enter DONE for 1 cycle (done=1, busy=0), then return to IDLE.
REQ-030 Total busy cycles SHALL equal 15*N: 240 for N=16.
REQ-031 At the clock edge ending a CMP cycle with eq=0:
- fail SHALL be set;
- fail_count SHALL increment unless it is 255;
- if fail was 0 beforehand, fail_addr SHALL capture addr.
REQ-032 A mismatch SHALL NOT abort the run.
REQ-033 start while busy or in DONE SHALL be ignored.
REQ-034 start in IDLE SHALL clear fail, fail_addr and fail_count in the same edge it launches the run.
REQ-035 fail, fail_addr and fail_count SHALL hold after done until the next accepted start.
REQ-036 Address wrap (N-1 -> 0 up, 0 -> N-1 down) SHALL only advance the element and SHALL never repeat an address.

Reset
REQ-037 While rst_n=0, the block SHALL be in IDLE with every output at 0: addr, data_t, we, re, cmp_en, busy, done, fail, fail_addr, fail_count.
REQ-038 Reset asserted mid-run SHALL abort the run immediately, with no done pulse and the fail state cleared.
REQ-039 After reset deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-040 Fault-free 16x8 RAM model, start pulse -> busy for exactly 240 cycles, done pulse, fail=0, fail_count=0.
REQ-041 RAM with bit0 stuck-at-0 at addr 5 -> fail=1, fail_addr=5, fail_count=2 (mismatches on the M2 and M4 r1 reads).
REQ-042 Sequence check, fault-free -> first M3 op is RD at addr 15; first M0 op is WR addr 0 with data_t=8'h00; M1 WR data_t=8'hFF.
REQ-043 rst_n low for 1 cycle at cycle 100 of a run -> all outputs 0, no done pulse; a fresh start then completes in 240 cycles.
REQ-044 start re-pulsed at busy cycle 50 -> ignored, done still at cycle 240; a second run after the failing run -> fail cleared at start, fail_count reflects only the new run.
REQ-045 Every cycle in all scenarios -> we+re+cmp_en <= 1, and cmp_en only in the cycle after re at the same addr.
